alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter ALU_LATENCY, default 1, is the number of clk cycles operands and alu_ctrl are held stable before alu_result/alu_zero are sampled; the legal range is 1-15.
REQ-002 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, is the asynchronous, active-low reset.
REQ-004 Port req_valid, input, 1, means a request is offered.
REQ-005 Port req_ready, output, 1, means the sequencer accepts a request this cycle.
REQ-006 Port req_aluop, input, 2, is the main-decoder ALUOp: 00 load/store, 01 branch, 10 R-type, 11 illegal.
REQ-007 Port req_funct, input, 6, is the R-type funct field.
REQ-008 Ports req_a and req_b, input, 32 each, are operand A and operand B.
REQ-009 Ports alu_in1 and alu_in2, output, 32 each, drive ALU InputData1 and InputData2.
REQ-010 Port alu_ctrl, output, 4, drives ALU_Control.
REQ-011 Port alu_result, input, 32, is ALU_Result from the ALU.
REQ-012 Port alu_zero, input, 1, is Zero from the ALU.
REQ-013 Port rsp_valid, output, 1, means a response is presented.
REQ-014 Port rsp_ready, input, 1, means the consumer takes the response.
REQ-015 Port rsp_result, output, 32, is the captured ALU result.
REQ-016 Port rsp_zero, output, 1, is the captured Zero.
REQ-017 Port rsp_err, output, 1, flags an illegal operation.

Function
REQ-018 The block SHALL implement the FSM states IDLE, EXEC and RESP, one-hot or binary; IDLE is the reset state.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-020 On accept, the block SHALL decode alu_ctrl as follows: ALUOp 00 gives 1 (ADD); ALUOp 01 gives 2 (SUB); ALUOp 10 with funct 0x20 gives 1 (ADD), 0x22 gives 2 (SUB), 0x24 gives 3 (AND), 0x25 gives 4 (OR), 0x27 gives 5 (NOR), 0x2A gives 6 (SLT), 0x2B gives 7 (SLTU), 0x00 gives 8 (SLL), 0x02 gives 9 (SRL).
REQ-021 ALUOp 11, or ALUOp 10 with any other funct, SHALL be illegal.
REQ-022 On a legal accept, the block SHALL register alu_in1=req_a, alu_in2=req_b and alu_ctrl=code, load the wait counter with ALU_LATENCY, and enter EXEC.
REQ-023 alu_in1, alu_in2 and alu_ctrl SHALL hold their values until the next legal accept.
REQ-024 In EXEC, the counter SHALL decrement each cycle; on the edge where it reaches 0, the block SHALL capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_err=0, and enter RESP.
REQ-025 For a legal request accepted at edge N, rsp_valid SHALL first be 1 after edge N+ALU_LATENCY.
REQ-026 ALU output changes before the capture edge SHALL NOT affect the response.
REQ-027 On an illegal accept, the block SHALL go directly to RESP on the next edge with rsp_result=0, rsp_zero=0 and rsp_err=1; alu_in1, alu_in2 and alu_ctrl SHALL be left unchanged.
REQ-028 rsp_valid SHALL be 1 only in RESP; while rsp_valid=1 and rsp_ready=0, rsp_result, rsp_zero and rsp_err SHALL be held stable.
REQ-029 In RESP with rsp_ready=1, the block SHALL return to IDLE on the next edge, so req_ready=1 in the following cycle; there SHALL be no request/response overlap.
REQ-030 req_valid SHALL be ignored outside IDLE, and req_* fields SHALL be sampled only at accept.
REQ-031 rsp_ready asserted outside RESP SHALL have no effect.
REQ-032 The counter width SHALL be 4 bits, and it SHALL never wrap.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, counter=0, alu_in1=0, alu_in2=0, alu_ctrl=0, rsp_valid=0, rsp_result=0, rsp_zero=0 and rsp_err=0.
REQ-034 req_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-035 Reset asserted in EXEC or RESP SHALL abort the operation, and no response SHALL be emitted for it.

Verification
REQ-036 Bench case 1, with L=1: aluop=10, funct=0x20, a=0xFFFFFFFF, b=1, ALU model -> alu_ctrl=1; rsp_result=0x00000000, rsp_zero=1, rsp_err=0; rsp_valid one cycle after accept.
REQ-037 Bench case 2: aluop=01, a=5, b=5 -> alu_ctrl=2, rsp_zero=1; then a=5, b=4 -> rsp_result=1, rsp_zero=0.
REQ-038 Bench case 3: aluop=10, funct=0x3F, after a prior ADD -> rsp_err=1, rsp_result=0; alu_ctrl stays 1; rsp_valid the next cycle.
REQ-039 Bench case 4: rsp_ready=0 for 3 cycles in RESP while req_valid=1 with new fields -> response stable, req_ready=0, the new request is not accepted until the cycle after the rsp_ready=1 handshake.
REQ-040 Bench case 5, with L=3: the ALU model changes alu_result at edges N+1 and N+2, and returns 0x1234 at N+3 -> rsp_result=0x1234.
REQ-041 Bench case 6: rst_n pulsed low mid-EXEC -> all outputs 0 immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that decodes ALUOp/funct into an ALU control code,
// holds operands for ALU_LATENCY cycles, then captures the ALU result.
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [3:0] dec_code;
  logic       dec_legal;
  logic       accept;
  logic       exec_done;

  always_comb begin
    dec_code  = '0;
    dec_legal = 1'b0;
    unique case (req_aluop)
      2'b00: begin dec_code = 4'd1; dec_legal = 1'b1; end
      2'b01: begin dec_code = 4'd2; dec_legal = 1'b1; end
      2'b10: begin
        dec_legal = 1'b1;
        case (req_funct)
          6'h20:   dec_code = 4'd1;
          6'h22:   dec_code = 4'd2;
          6'h24:   dec_code = 4'd3;
          6'h25:   dec_code = 4'd4;
          6'h27:   dec_code = 4'd5;
          6'h2A:   dec_code = 4'd6;
          6'h2B:   dec_code = 4'd7;
          6'h00:   dec_code = 4'd8;
          6'h02:   dec_code = 4'd9;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  // Counter reaches zero on this edge; <= also covers a stray zero count.
  assign exec_done = (state == EXEC) && (cnt <= 4'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = dec_legal ? EXEC : RESP;
      EXEC: if (exec_done) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_ctrl   <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && dec_legal) begin
        alu_in1  <= req_a;
        alu_in2  <= req_b;
        alu_ctrl <= dec_code;
        cnt      <= LAT;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (accept && !dec_legal) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end else if (exec_done) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at latency 1 driven by an
// ALU model, one at latency 3 whose ALU result is driven step by step.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid3;
  logic        req_ready, req_ready3;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_in1, alu_in2, alu_in1_3, alu_in2_3;
  logic [3:0]  alu_ctrl, alu_ctrl3;
  logic [31:0] alu_result, alu_result3;
  logic        alu_zero, alu_zero3;
  logic        rsp_valid, rsp_valid3;
  logic        rsp_ready;
  logic [31:0] rsp_result, rsp_result3;
  logic        rsp_zero, rsp_zero3, rsp_err, rsp_err3;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err));

  alu_op_sequencer #(.ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1_3), .alu_in2(alu_in2_3), .alu_ctrl(alu_ctrl3),
    .alu_result(alu_result3), .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_err(rsp_err3));

  // Reference ALU for the latency-1 instance.
  always_comb begin
    case (alu_ctrl)
      4'd1:    alu_result = alu_in1 + alu_in2;
      4'd2:    alu_result = alu_in1 - alu_in2;
      4'd3:    alu_result = alu_in1 & alu_in2;
      4'd4:    alu_result = alu_in1 | alu_in2;
      4'd5:    alu_result = ~(alu_in1 | alu_in2);
      4'd6:    alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      4'd7:    alu_result = {31'd0, alu_in1 < alu_in2};
      4'd8:    alu_result = alu_in1 << alu_in2[4:0];
      4'd9:    alu_result = alu_in1 >> alu_in2[4:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request to the latency-1 instance; returns one step after the accept edge.
  task automatic do_req(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_aluop = op; req_funct = fn; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid_low", rsp_valid, 0);
    chk("hs_req_ready", req_ready, 1);
  endtask

  logic [5:0] fn_tab   [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};
  logic [3:0] code_tab [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0;
    req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
    alu_result3 = '0; alu_zero3 = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;
    #1 chk("rel_req_ready", req_ready, 1);
    tick();

    // Case 1: R-type ADD wrapping to zero
    do_req(2'b10, 6'h20, 32'hFFFF_FFFF, 32'h1);
    chk("c1_alu_ctrl", alu_ctrl, 1);
    chk("c1_alu_in1", alu_in1, 32'hFFFF_FFFF);
    chk("c1_rsp_valid_early", rsp_valid, 0);
    chk("c1_req_ready_busy", req_ready, 0);
    tick();
    chk("c1_rsp_valid", rsp_valid, 1);
    chk("c1_rsp_result", rsp_result, 0);
    chk("c1_rsp_zero", rsp_zero, 1);
    chk("c1_rsp_err", rsp_err, 0);
    handshake();

    // Case 2: branch SUB, equal then unequal
    do_req(2'b01, 6'h3F, 32'd5, 32'd5);
    chk("c2_alu_ctrl", alu_ctrl, 2);
    tick();
    chk("c2a_rsp_zero", rsp_zero, 1);
    chk("c2a_rsp_result", rsp_result, 0);
    handshake();
    do_req(2'b01, 6'h00, 32'd5, 32'd4);
    tick();
    chk("c2b_rsp_result", rsp_result, 1);
    chk("c2b_rsp_zero", rsp_zero, 0);
    handshake();

    // Case 3: ADD then illegal funct; illegal leaves ALU-side registers alone
    do_req(2'b00, 6'h00, 32'd3, 32'd4);
    tick();
    chk("c3_add_result", rsp_result, 7);
    handshake();
    do_req(2'b10, 6'h3F, 32'd99, 32'd98);
    chk("c3_rsp_valid", rsp_valid, 1);
    chk("c3_rsp_err", rsp_err, 1);
    chk("c3_rsp_result", rsp_result, 0);
    chk("c3_rsp_zero", rsp_zero, 0);
    chk("c3_alu_ctrl_kept", alu_ctrl, 1);
    chk("c3_alu_in1_kept", alu_in1, 3);
    handshake();
    do_req(2'b11, 6'h20, 32'd1, 32'd1);
    chk("c3_op11_err", rsp_err, 1);
    chk("c3_op11_ctrl_kept", alu_ctrl, 1);
    handshake();

    // Case 4: back-pressure with a competing request pending
    do_req(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("c4_slt_result", rsp_result, 1);
    req_valid = 1'b1; req_aluop = 2'b10; req_funct = 6'h24;
    req_a = 32'h0000_F0F0; req_b = 32'h0000_FF00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c4_hold_valid", rsp_valid, 1);
      chk("c4_hold_result", rsp_result, 1);
      chk("c4_hold_req_ready", req_ready, 0);
      chk("c4_hold_ctrl", alu_ctrl, 6);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("c4_idle_ready", req_ready, 1);
    chk("c4_not_yet_accepted", alu_ctrl, 6);
    tick();
    req_valid = 1'b0;
    chk("c4_accepted_ctrl", alu_ctrl, 3);
    tick();
    chk("c4_and_result", rsp_result, 32'h0000_F000);
    handshake();

    // Decode table sweep of every legal funct
    for (int i = 0; i < 9; i++) begin
      do_req(2'b10, fn_tab[i], 32'h8000_0010, 32'd4);
      chk("tab_ctrl", alu_ctrl, code_tab[i]);
      tick();
      chk("tab_err", rsp_err, 0);
      handshake();
    end

    // Case 5: latency 3, only the value present at the capture edge counts
    req_valid3 = 1'b1; req_aluop = 2'b00; req_a = 32'd1; req_b = 32'd2;
    alu_result3 = 32'hAAAA; alu_zero3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    chk("c5_ctrl", alu_ctrl3, 1);
    chk("c5_valid_n0", rsp_valid3, 0);
    alu_result3 = 32'h1111;
    tick();
    chk("c5_valid_n1", rsp_valid3, 0);
    alu_result3 = 32'h2222;
    tick();
    chk("c5_valid_n2", rsp_valid3, 0);
    alu_result3 = 32'h1234; alu_zero3 = 1'b0;
    tick();
    chk("c5_valid_n3", rsp_valid3, 1);
    chk("c5_result", rsp_result3, 32'h1234);
    chk("c5_zero", rsp_zero3, 0);
    alu_result3 = 32'hDEAD;
    tick();
    chk("c5_result_held", rsp_result3, 32'h1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("c5_done", rsp_valid3, 0);
    chk("c5_dut1_unaffected", rsp_valid, 0);

    // Case 6: reset mid-EXEC aborts the operation
    do_req(2'b00, 6'h00, 32'd10, 32'd20);
    rst_n = 1'b0;
    #1;
    chk("c6_alu_in1", alu_in1, 0);
    chk("c6_alu_in2", alu_in2, 0);
    chk("c6_alu_ctrl", alu_ctrl, 0);
    chk("c6_rsp_valid", rsp_valid, 0);
    chk("c6_req_ready_low", req_ready, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("c6_req_ready", req_ready, 1);
    tick();
    chk("c6_no_rsp", rsp_valid, 0);
    chk("c6_result", rsp_result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
